vid_timing_gen: RTL and testbench

Video timing generator clocked by the 74.25 MHz video PLL output. It qualifies the PLL `locked` flag, then produces CEA-861 1280x720p60 raster timing. Outputs are hsync, vsync, data-enable, pixel coordinates and a frame-start strobe. It sits directly downstream of the video PLL and feeds the pixel source and HDMI/VGA output stage.

---
 rtl/vid_timing_gen.sv | 162 ++++++++++++++++
 tb/tb_vid_timing_gen.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vid_timing_gen.sv
// Video raster timing generator.
// Waits for the PLL lock flag to be stable for LOCK_WAIT cycles, then runs
// horizontal/vertical counters and decodes them into registered sync,
// data-enable, coordinate and frame-start outputs. Losing lock abandons the
// frame; after requalification the raster always restarts at pixel (0,0).
module vid_timing_gen #(
  parameter int H_ACTIVE  = 1280,
  parameter int H_FP      = 110,
  parameter int H_SYNC    = 40,
  parameter int H_BP      = 220,
  parameter int V_ACTIVE  = 720,
  parameter int V_FP      = 5,
  parameter int V_SYNC    = 5,
  parameter int V_BP      = 20,
  parameter bit HS_POL    = 1'b1,
  parameter bit VS_POL    = 1'b1,
  parameter int LOCK_WAIT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        locked,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [11:0] x,
  output logic [10:0] y,
  output logic        frame_start,
  output logic        running
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int LCW     = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;

  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_WAIT - 1);
  localparam logic [11:0]    H_LAST    = 12'(H_TOTAL - 1);
  localparam logic [10:0]    V_LAST    = 11'(V_TOTAL - 1);
  localparam logic [11:0]    HS_START  = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0]    HS_END    = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0]    VS_START  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0]    VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {
    WAIT_LOCK = 1'b0,
    RUN       = 1'b1
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            locked_m;
  logic            locked_s;
  logic [LCW-1:0]  lock_cnt;
  logic [LCW-1:0]  lock_cnt_next;
  logic [11:0]     h_cnt;
  logic [11:0]     h_cnt_next;
  logic [10:0]     v_cnt;
  logic [10:0]     v_cnt_next;
  logic            run_ok;
  logic            de_n;
  logic            hs_n;
  logic            vs_n;
  logic            fs_n;

  // Two-flop synchronizer bringing the asynchronous PLL lock flag into clk.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      locked_m <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      locked_m <= locked;
      locked_s <= locked_m;
    end
  end

  // State, lock qualification counter and raster counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= WAIT_LOCK;
      lock_cnt <= '0;
      h_cnt    <= '0;
      v_cnt    <= '0;
    end else begin
      state    <= state_next;
      lock_cnt <= lock_cnt_next;
      h_cnt    <= h_cnt_next;
      v_cnt    <= v_cnt_next;
    end
  end

  // Next-state logic: qualify lock, then step the raster; lock loss restarts.
  always_comb begin
    state_next    = state;
    lock_cnt_next = lock_cnt;
    h_cnt_next    = h_cnt;
    v_cnt_next    = v_cnt;
    case (state)
      WAIT_LOCK: begin
        h_cnt_next = '0;
        v_cnt_next = '0;
        if (!locked_s) begin
          lock_cnt_next = '0;
        end else if (lock_cnt == LOCK_LAST) begin
          state_next    = RUN;
          lock_cnt_next = '0;
        end else begin
          lock_cnt_next = lock_cnt + LCW'(1);
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_next    = WAIT_LOCK;
          lock_cnt_next = '0;
          h_cnt_next    = '0;
          v_cnt_next    = '0;
        end else if (h_cnt == H_LAST) begin
          h_cnt_next = '0;
          v_cnt_next = (v_cnt == V_LAST) ? 11'd0 : v_cnt + 11'd1;
        end else begin
          h_cnt_next = h_cnt + 12'd1;
        end
      end
      default: begin
        state_next    = WAIT_LOCK;
        lock_cnt_next = '0;
        h_cnt_next    = '0;
        v_cnt_next    = '0;
      end
    endcase
  end

  // Counter decodes; gating with locked_s makes outputs drop on the same edge
  // that leaves RUN instead of one cycle later.
  always_comb begin
    run_ok = (state == RUN) && locked_s;
    de_n   = run_ok && (h_cnt < 12'(H_ACTIVE)) && (v_cnt < 11'(V_ACTIVE));
    hs_n   = run_ok && (h_cnt >= HS_START) && (h_cnt < HS_END);
    vs_n   = run_ok && (v_cnt >= VS_START) && (v_cnt < VS_END);
    fs_n   = run_ok && (h_cnt == 12'd0) && (v_cnt == 11'd0);
  end

  // Registered outputs; coordinates are forced to zero during blanking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      de          <= 1'b0;
      frame_start <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      x           <= '0;
      y           <= '0;
    end else begin
      de          <= de_n;
      frame_start <= fs_n;
      hsync       <= hs_n ? HS_POL : ~HS_POL;
      vsync       <= vs_n ? VS_POL : ~VS_POL;
      x           <= de_n ? h_cnt : 12'd0;
      y           <= de_n ? v_cnt : 11'd0;
    end
  end

  assign running = (state == RUN);

endmodule

// File: tb/tb_vid_timing_gen.sv
// Testbench for vid_timing_gen using a reduced raster so that whole frames
// fit in a short run. Expected raster outputs come from a position-based
// model (cycle index since frame start) queued and compared each cycle.
module tb_vid_timing_gen;

  localparam int HA  = 16;
  localparam int HF  = 3;
  localparam int HSW = 4;
  localparam int HB  = 5;
  localparam int HT  = HA + HF + HSW + HB;
  localparam int VA  = 6;
  localparam int VF  = 2;
  localparam int VSW = 2;
  localparam int VB  = 3;
  localparam int VT  = VA + VF + VSW + VB;
  localparam bit HP  = 1'b1;
  localparam bit VP  = 1'b0;
  localparam int LW  = 16;
  localparam int FRAME = HT * VT;
  localparam int W   = 27;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        locked = 1'b0;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic [11:0] x;
  logic [10:0] y;
  logic        frame_start;
  logic        running;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  // Clock and reset block.
  always #5 clk = ~clk;

  vid_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(HP), .VS_POL(VP), .LOCK_WAIT(LW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .locked(locked),
    .hsync(hsync),
    .vsync(vsync),
    .de(de),
    .x(x),
    .y(y),
    .frame_start(frame_start),
    .running(running)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] obs();
    return {de, hsync, vsync, frame_start, x, y};
  endfunction

  function automatic logic [W-1:0] model(input int p);
    int h;
    int v;
    logic m_de, m_hs, m_vs, m_fs;
    logic [11:0] mx;
    logic [10:0] my;
    h    = p % HT;
    v    = (p / HT) % VT;
    m_de = (h < HA) && (v < VA);
    m_hs = (h >= HA + HF) && (h < HA + HF + HSW);
    m_vs = (v >= VA + VF) && (v < VA + VF + VSW);
    m_fs = (h == 0) && (v == 0);
    mx   = m_de ? 12'(h) : 12'd0;
    my   = m_de ? 11'(v) : 11'd0;
    return {m_de, m_hs ? HP : ~HP, m_vs ? VP : ~VP, m_fs, mx, my};
  endfunction

  task automatic test_reset();
    logic [W:0] exp_v;
    logic [W:0] got_v;
    rst_n  = 1'b0;
    locked = 1'b1;
    exp_v  = {1'b0, ~HP, ~VP, 1'b0, 12'd0, 11'd0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      tick();
      got_v = {obs(), running};
      n_checks++;
      if (got_v !== exp_v) begin
        n_errors++;
        $display("FAIL reset_values cycle %0d: got %h expected %h", i, got_v, exp_v);
      end
    end
  endtask

  task automatic test_bringup();
    int n;
    rst_n = 1'b1;
    n = 0;
    while (!running && n < 200) begin
      tick();
      n++;
    end
    n_checks++;
    if (!running || n < LW + 1 || n > LW + 3) begin
      n_errors++;
      $display("FAIL bringup_latency: got %0d cycles (running=%b) expected %0d +/-1", n, running, LW + 2);
    end
    n_checks++;
    if (de !== 1'b0 || frame_start !== 1'b0) begin
      n_errors++;
      $display("FAIL first_run_cycle: got de=%b fs=%b expected de=0 fs=0", de, frame_start);
    end
  endtask

  task automatic test_frames();
    logic [W-1:0] got, exp;
    int p_de, p_hs, p_fs, de_cnt, vs_cnt, de_lines;
    logic prev_de, prev_hs, hs_act, vs_act;
    p_de = -100000; p_hs = -100000; p_fs = -1;
    de_cnt = 0; vs_cnt = 0; de_lines = 0;
    prev_de = 1'b0; prev_hs = 1'b0;
    for (int p = 0; p <= 2 * FRAME; p++) begin
      exp_q.push_back(model(p));
      tick();
      got = obs();
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL raster p=%0d: got %h expected %h", p, got, exp);
      end
      hs_act = (hsync == HP);
      vs_act = (vsync == VP);
      if (frame_start) begin
        if (p_fs >= 0) begin
          n_checks++;
          if (p - p_fs != FRAME) begin
            n_errors++;
            $display("FAIL fs_period: got %0d expected %0d", p - p_fs, FRAME);
          end
          n_checks++;
          if (de_cnt != HA * VA || de_lines != VA || vs_cnt != VSW * HT) begin
            n_errors++;
            $display("FAIL frame_totals: got de=%0d lines=%0d vs=%0d expected %0d %0d %0d",
                     de_cnt, de_lines, vs_cnt, HA * VA, VA, VSW * HT);
          end
        end else begin
          n_checks++;
          if (x !== 12'd0 || y !== 11'd0 || de !== 1'b1) begin
            n_errors++;
            $display("FAIL first_pixel: got x=%0d y=%0d de=%b expected 0 0 1", x, y, de);
          end
        end
        p_fs = p; de_cnt = 0; vs_cnt = 0; de_lines = 0;
      end
      if (de) de_cnt++;
      if (vs_act) vs_cnt++;
      if (de && !prev_de) begin
        if (de_lines > 0) begin
          n_checks++;
          if (p - p_de != HT) begin
            n_errors++;
            $display("FAIL line_period: got %0d expected %0d", p - p_de, HT);
          end
        end
        de_lines++;
        p_de = p;
      end
      if (!de && prev_de) begin
        n_checks++;
        if (p - p_de != HA) begin
          n_errors++;
          $display("FAIL de_width: got %0d expected %0d", p - p_de, HA);
        end
      end
      if (hs_act && !prev_hs) begin
        if (p - p_de < HT) begin
          n_checks++;
          if (p - p_de != HA + HF) begin
            n_errors++;
            $display("FAIL hsync_start: got %0d expected %0d", p - p_de, HA + HF);
          end
        end
        p_hs = p;
      end
      if (!hs_act && prev_hs) begin
        n_checks++;
        if (p - p_hs != HSW) begin
          n_errors++;
          $display("FAIL hsync_width: got %0d expected %0d", p - p_hs, HSW);
        end
      end
      prev_de = de;
      prev_hs = hs_act;
    end
  endtask

  task automatic test_lock_loss();
    int p;
    int n;
    logic [W-1:0] exp;
    // Raster continues from position 2*FRAME+1; move into line 3, pixel 5.
    p = 2 * FRAME;
    for (int i = 0; i < 3 * HT + 5; i++) begin
      tick();
      p++;
    end
    exp = model(p);
    n_checks++;
    if (obs() !== exp) begin
      n_errors++;
      $display("FAIL pre_loss_position: got %h expected %h", obs(), exp);
    end
    locked = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 3) begin
        n_checks++;
        if ({de, hsync, vsync, frame_start, running, x, y} !==
            {1'b0, ~HP, ~VP, 1'b0, 1'b0, 12'd0, 11'd0}) begin
          n_errors++;
          $display("FAIL loss_inactive: got de=%b hs=%b vs=%b fs=%b run=%b x=%0d y=%0d",
                   de, hsync, vsync, frame_start, running, x, y);
        end
      end
    end
    locked = 1'b1;
    n = 0;
    while (!running && n < 200) begin
      tick();
      n++;
    end
    n_checks++;
    if (!running || n < LW + 1 || n > LW + 3) begin
      n_errors++;
      $display("FAIL relock_latency: got %0d cycles expected %0d +/-1", n, LW + 2);
    end
    tick();
    n_checks++;
    if (frame_start !== 1'b1 || de !== 1'b1 || x !== 12'd0 || y !== 11'd0) begin
      n_errors++;
      $display("FAIL restart_origin: got fs=%b de=%b x=%0d y=%0d expected 1 1 0 0", frame_start, de, x, y);
    end
    tick();
    n_checks++;
    if (frame_start !== 1'b0 || de !== 1'b1 || x !== 12'd1 || y !== 11'd0) begin
      n_errors++;
      $display("FAIL restart_next: got fs=%b de=%b x=%0d y=%0d expected 0 1 1 0", frame_start, de, x, y);
    end
  endtask

  task automatic test_glitch_and_reset();
    int n;
    logic [W:0] exp_v;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 11; i++) tick();
    locked = 1'b0;
    tick();
    locked = 1'b1;
    n = 0;
    while (!running && n < 200) begin
      tick();
      n++;
    end
    n_checks++;
    if (!running || n < LW + 1 || n > LW + 3) begin
      n_errors++;
      $display("FAIL glitch_requalify: got %0d cycles expected %0d +/-1", n, LW + 2);
    end
    for (int i = 0; i < 6; i++) tick();
    n_checks++;
    if (de !== 1'b1 || x !== 12'd5) begin
      n_errors++;
      $display("FAIL pre_reset_line: got de=%b x=%0d expected 1 5", de, x);
    end
    exp_v = {1'b0, ~HP, ~VP, 1'b0, 12'd0, 11'd0, 1'b0};
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if ({obs(), running} !== exp_v) begin
        n_errors++;
        $display("FAIL midline_reset cycle %0d: got %h expected %h", i, {obs(), running}, exp_v);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_frames();
    test_lock_loss();
    test_glitch_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
